// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and funct3 decode for the load/store unit.
// Used by lsu and lsu_align.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only know B/H/W; anything else is a word.
  function automatic lsu_size_t f3_size(
    input logic [2:0] f3,
    input logic       st
  );
    if (f3 == F3_B || (!st && f3 == F3_BU))
      return SZ_B;
    if (f3 == F3_H || (!st && f3 == F3_HU))
      return SZ_H;
    return SZ_W;
  endfunction

  function automatic logic is_misaligned(
    input lsu_size_t  sz,
    input logic [1:0] a
  );
    return (sz == SZ_H && a[0]) ||
           (sz == SZ_W && a != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-enable generation, store lane steering
// and load extraction/extension (combinational).
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_t   i_size,
  input  logic        i_sext,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_rdata[31:16]
                            : i_rdata[15:0];

  // Lane select by access size; low bits beyond size ignored.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    unique case (1'b1)
      (i_size == SZ_B): begin
        o_be    = 4'b0001 << i_addr;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_sext & w_byte[7]}}, w_byte};
      end
      (i_size == SZ_H): begin
        o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_sext & w_half[15]}}, w_half};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: memory-stage load/store unit, req/gnt/rvalid port.
// Option: LSU_MISALIGN_TRAP_EN enables the misaligned trap.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           ALUout,
  input  logic [31:0]           store_data,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  output logic                  stall,
  output logic [31:0]           load_result,
  output logic                  done,
  output logic                  misaligned,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [31:0]           dmem_rdata
);

  lsu_state_t            r_state;
  lsu_state_t            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_f3;
  logic                  r_we;
  logic [31:0]           r_load_result;
  logic                  w_go;
  logic                  w_trap;
  logic                  w_req;
  lsu_size_t             w_size;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_ext;

  assign w_go = mem_read | mem_write;

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_mis;
  assign w_trap = is_misaligned(
    f3_size(funct3, mem_write), ALUout[1:0]);
  assign misaligned = (r_state == DONE) & r_mis;
`else
  assign w_trap     = 1'b0;
  assign misaligned = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state: accept, wait for grant, wait for read data.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:
        if (w_go)
          w_state_nxt = w_trap ? DONE : REQ;
      REQ:
        if (dmem_gnt)
          w_state_nxt = r_we ? DONE : WAIT;
      WAIT:
        if (dmem_rvalid)
          w_state_nxt = DONE;
      default:
        w_state_nxt = IDLE;
    endcase
  end

  // Latch the request on accept and capture load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr        <= '0;
      r_wdata       <= '0;
      r_f3          <= '0;
      r_we          <= 1'b0;
      r_load_result <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_mis         <= 1'b0;
`endif
    end else begin
      if (r_state == IDLE && w_go) begin
        r_addr  <= ALUout[ADDR_WIDTH-1:0];
        r_wdata <= store_data;
        r_f3    <= funct3;
        r_we    <= mem_write;
`ifdef LSU_MISALIGN_TRAP_EN
        r_mis   <= w_trap;
        if (w_trap && !mem_write)
          r_load_result <= '0;
`endif
      end
      if (r_state == WAIT && dmem_rvalid)
        r_load_result <= w_ext;
    end
  end

  assign w_size = f3_size(r_f3, r_we);

  lsu_align u_align (
    .i_size  (w_size),
    .i_sext  (~r_f3[2]),
    .i_addr  (r_addr[1:0]),
    .i_wdata (r_wdata),
    .i_rdata (dmem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rdata (w_ext)
  );

  assign w_req       = (r_state == REQ);
  assign dmem_req    = w_req;
  assign dmem_we     = w_req & r_we;
  assign dmem_be     = w_req ? w_be : 4'b0000;
  assign dmem_wdata  = dmem_we ? w_wdata : 32'h0;
  assign dmem_addr   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign done        = (r_state == DONE);
  assign stall       = w_go & (r_state != DONE);
  assign load_result = r_load_result;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu.
// Expected values are hand-computed constants.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUout;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic        stall;
  logic [31:0] load_result;
  logic        done;
  logic        misaligned;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu #(.ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ALUout      (ALUout),
    .store_data  (store_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .stall       (stall),
    .load_result (load_result),
    .done        (done),
    .misaligned  (misaligned),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  // One load; gnt arrives gdly cycles late, rvalid one after.
  task automatic run_load(
    input  logic [31:0] a,
    input  logic [2:0]  f3,
    input  logic [31:0] rd,
    input  int          gdly,
    output int          dcyc,
    output int          scnt,
    output logic        sd,
    output logic [31:0] lr,
    output logic        mis,
    output logic        sreq,
    output logic [31:0] raddr,
    output logic [3:0]  rbe
  );
    int cyc;
    dcyc  = -1;
    scnt  = 0;
    sd    = 1'b1;
    lr    = '0;
    mis   = 1'b0;
    sreq  = 1'b0;
    raddr = '0;
    rbe   = '0;
    ALUout      = a;
    funct3      = f3;
    mem_read    = 1'b1;
    mem_write   = 1'b0;
    dmem_rdata  = rd;
    cyc         = 0;
    dmem_gnt    = (cyc == gdly + 1);
    dmem_rvalid = (cyc == gdly + 2);
    while (cyc < 40 && dcyc < 0) begin
      @(negedge clk);
      if (dmem_req && !sreq) begin
        sreq  = 1'b1;
        raddr = dmem_addr;
        rbe   = dmem_be;
      end
      if (done) begin
        dcyc = cyc;
        sd   = stall;
        lr   = load_result;
        mis  = misaligned;
      end else if (stall) begin
        scnt++;
      end
      @(posedge clk); #1;
      cyc++;
      dmem_gnt    = (cyc == gdly + 1);
      dmem_rvalid = (cyc == gdly + 2);
    end
    mem_read    = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    int          dc;
    int          sc;
    logic        sd;
    logic        mis;
    logic        sreq;
    logic [31:0] lr;
    logic [31:0] ra;
    logic [3:0]  be;
    logic [31:0] lr_keep;

    rst         = 1'b1;
    ALUout      = '0;
    store_data  = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    funct3      = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_lr",   load_result, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_mis",  {31'b0, misaligned}, 32'h0);
    check("rst_req",  {31'b0, dmem_req}, 32'h0);
    check("rst_we",   {31'b0, dmem_we}, 32'h0);
    check("rst_be",   {28'b0, dmem_be}, 32'h0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wd",   dmem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SB with immediate grant
    ALUout     = 32'h1003;
    store_data = 32'h0000_00A5;
    funct3     = 3'b000;
    mem_write  = 1'b1;
    dmem_gnt   = 1'b1;
    @(negedge clk);
    check("sb_c0_stall", {31'b0, stall}, 32'h1);
    check("sb_c0_req",   {31'b0, dmem_req}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("sb_c1_req",   {31'b0, dmem_req}, 32'h1);
    check("sb_c1_we",    {31'b0, dmem_we}, 32'h1);
    check("sb_c1_addr",  dmem_addr, 32'h1000);
    check("sb_c1_be",    {28'b0, dmem_be}, 32'h8);
    check("sb_c1_wd",    dmem_wdata, 32'hA5A5_A5A5);
    check("sb_c1_stall", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("sb_c2_done",  {31'b0, done}, 32'h1);
    check("sb_c2_stall", {31'b0, stall}, 32'h0);
    check("sb_c2_lr",    load_result, 32'h0);
    @(posedge clk); #1;
    mem_write = 1'b0;
    dmem_gnt  = 1'b0;
    @(negedge clk);
    check("sb_c3_done",  {31'b0, done}, 32'h0);

    // LB / LBU at 0x2001
    run_load(32'h2001, 3'b000, 32'h0000_8000, 0,
             dc, sc, sd, lr, mis, sreq, ra, be);
    check("lb_dcyc",  dc, 32'd3);
    check("lb_stall", sc, 32'd3);
    check("lb_be",    {28'b0, be}, 32'h2);
    check("lb_lr",    lr, 32'hFFFF_FF80);
    run_load(32'h2001, 3'b100, 32'h0000_8000, 0,
             dc, sc, sd, lr, mis, sreq, ra, be);
    check("lbu_dcyc", dc, 32'd3);
    check("lbu_lr",   lr, 32'h0000_0080);

    // LH at 0x2002, grant three cycles late
    run_load(32'h2002, 3'b001, 32'h8001_0000, 3,
             dc, sc, sd, lr, mis, sreq, ra, be);
    check("lh_dcyc",    dc, 32'd6);
    check("lh_stall",   sc, 32'd6);
    check("lh_sdone",   {31'b0, sd}, 32'h0);
    check("lh_be",      {28'b0, be}, 32'hC);
    check("lh_addr",    ra, 32'h2000);
    check("lh_lr",      lr, 32'hFFFF_8001);

    // reset while waiting for read data
    ALUout    = 32'h2000;
    funct3    = 3'b010;
    mem_read  = 1'b1;
    @(posedge clk); #1;
    dmem_gnt  = 1'b1;
    @(posedge clk); #1;
    dmem_gnt  = 1'b0;
    @(negedge clk);
    check("rw_pre_req", {31'b0, dmem_req}, 32'h0);
    check("rw_pre_lr",  load_result, 32'hFFFF_8001);
    rst      = 1'b1;
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst         = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rw_req",   {31'b0, dmem_req}, 32'h0);
    check("rw_done",  {31'b0, done}, 32'h0);
    check("rw_lr",    load_result, 32'h0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check("rw_done2", {31'b0, done}, 32'h0);
    check("rw_lr2",   load_result, 32'h0);

    // misaligned LW at 0x2002
    run_load(32'h2002, 3'b010, 32'h1234_5678, 0,
             dc, sc, sd, lr, mis, sreq, ra, be);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_dcyc", dc, 32'd1);
    check("mis_req",  {31'b0, sreq}, 32'h0);
    check("mis_flag", {31'b0, mis}, 32'h1);
    check("mis_lr",   lr, 32'h0);
    lr_keep = 32'h0;
`else
    check("mis_dcyc", dc, 32'd3);
    check("mis_req",  {31'b0, sreq}, 32'h1);
    check("mis_addr", ra, 32'h2000);
    check("mis_be",   {28'b0, be}, 32'hF);
    check("mis_flag", {31'b0, mis}, 32'h0);
    check("mis_lr",   lr, 32'h1234_5678);
    lr_keep = 32'h1234_5678;
`endif

    // SW with both read and write requested
    ALUout     = 32'h3000;
    store_data = 32'hCAFE_F00D;
    funct3     = 3'b010;
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    dmem_gnt   = 1'b1;
    @(negedge clk);
    check("sw_c0_stall", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("sw_we",   {31'b0, dmem_we}, 32'h1);
    check("sw_be",   {28'b0, dmem_be}, 32'hF);
    check("sw_wd",   dmem_wdata, 32'hCAFE_F00D);
    check("sw_addr", dmem_addr, 32'h3000);
    @(posedge clk); #1;
    @(negedge clk);
    check("sw_done", {31'b0, done}, 32'h1);
    check("sw_lr",   load_result, lr_keep);
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    dmem_gnt  = 1'b0;
    @(negedge clk);
    check("sw_idle", {31'b0, done}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the memory stage of the RV32I core, directly downstream of the ALU. It takes the ALU result as the effective address and rs2 as store data. It runs a request/grant/response transaction against the data memory port and returns a sign- or zero-extended load result. It asserts `stall` to freeze the pipeline until the access completes.

## Interface
- `ADDR_WIDTH`, 32: width of `dmem_addr`; the effective address is truncated to this width.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ALUout` in 32: effective address from the ALU.
- `store_data` in 32: rs2 value for stores.
- `mem_read` in 1: load requested; held by the pipeline while `stall`=1.
- `mem_write` in 1: store requested; held by the pipeline while `stall`=1; wins over `mem_read` if both are high.
- `funct3` in 3: size and sign. Decoding:
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - Other loads are treated as W; other stores as W.
- `stall` out 1: freezes upstream stages.
- `load_result` out 32: extended load data; registered.
- `done` out 1: single-cycle completion pulse.
- `misaligned` out 1: misaligned-access flag, valid with `done`.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: write enable.
- `dmem_addr` out ADDR_WIDTH: word address, always {addr[ADDR_WIDTH-1:2], 2'b00}.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-steered store data.
- `dmem_gnt` in 1: request accepted.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in 32: read data word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On `mem_read|mem_write`: latch address, store data, funct3 and op type, then go to REQ.
  - With the trap enabled and the access misaligned: go to DONE instead.
- REQ:
  - Drive `dmem_req`=1 from latched values; hold all `dmem_*` outputs stable until `dmem_gnt`.
  - On grant, a store goes to DONE and a load goes to WAIT.
- WAIT: on `dmem_rvalid`, extend `dmem_rdata` into `load_result`, then go to DONE.
  - `dmem_gnt` and `dmem_rvalid` in the same cycle are allowed; this cycle's rvalid is consumed only in WAIT.
- DONE: `done`=1, `stall`=0, then return to IDLE unconditionally.
- `stall` = (`mem_read`|`mem_write`) & state≠DONE. It is combinational, so it is asserted in the accept cycle.
- Store steering:
  - SB: `dmem_be` = 1<<addr[1:0]; byte replicated ×4.
  - SH: `dmem_be` = addr[1] ? 1100 : 0011; half replicated ×2.
  - SW: `dmem_be` = 1111.
- Load extraction:
  - Byte lane is addr[1:0]; half lane is addr[1].
  - B and H sign-extend; BU and HU zero-extend.
  - Load `dmem_be` follows the same size rule as stores.
- `load_result` holds its last value until the next load completes. Stores leave it unchanged.
- `dmem_rvalid` outside WAIT is ignored. `dmem_gnt` outside REQ is ignored.

## Timing
- Reset values: state IDLE, `load_result`=0, `done`=0, `misaligned`=0, `dmem_req`=0, `dmem_we`=0, `dmem_be`=0, `dmem_addr`=0, `dmem_wdata`=0.
- Store with immediate grant: accept cycle 0, REQ cycle 1, DONE cycle 2. `stall` is high in cycles 0–1.
- Load with immediate grant and rvalid one cycle later: cycles 0/1/2/3 are IDLE/REQ/WAIT/DONE. `load_result` is valid from cycle 3.
- Grant and rvalid waits are unbounded. `stall` stays high throughout.
- Reset mid-transaction: state returns to IDLE and `dmem_req` drops at that edge. Late rvalid or gnt is ignored.
- A new op presented in the DONE cycle is not accepted; it is accepted in the following IDLE cycle.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Misaligned means: H/HU with addr[0]=1, or W with addr[1:0]≠00.
- With the macro:
  - A misaligned access skips memory (no `dmem_req`, no write).
  - Path is IDLE→DONE: `done`=1 and `misaligned`=1 in cycle 1.
  - A load sets `load_result`=0.
- Without the macro:
  - `misaligned` is tied 0.
  - Low address bits beyond the size rule are ignored: a word access is forced aligned, and a half access uses addr[1] only.

## Structure
- `lsu_pkg` holds:
  - `lsu_state_t` enum.
  - funct3 localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
- Sub-module `lsu_align` is combinational. It takes size, addr[1:0] and data and produces `dmem_be`, steered `dmem_wdata` and the extended load value. It is instanced once in `lsu`.

## Test plan
- SB: ALUout=0x1003, store_data=0xA5, gnt immediate → `dmem_addr`=0x1000, `dmem_be`=1000, `dmem_wdata`=0xA5A5A5A5, `done` in cycle 2.
- LB and LBU: addr=0x2001, rdata=0x0000_8000 → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- LH: addr=0x2002, rdata=0x8001_0000, gnt delayed 3 cycles → `load_result`=0xFFFF8001; `stall` high for 6 cycles and low in the DONE cycle.
- Misaligned: LW at 0x2002.
  - Macro on → no `dmem_req`; `misaligned`=1 and `done`=1 in cycle 1.
  - Macro off → access to 0x2000 with `dmem_be`=1111.
- Reset in WAIT, then rvalid=1 with rdata=0xDEADBEEF the next cycle → state IDLE, `load_result`=0, no `done`.
- Both `mem_read` and `mem_write` high, SW at 0x3000 → `dmem_we`=1, `dmem_be`=1111.
